// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/halt FSM, jump control, retire counter.
// Define PC_SEQ_RAS_EN to build the return-address stack for call/return.
module pc_sequencer #(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall,
  input  logic [2:0]   br_kind,
  input  logic         cond_flag,
  input  logic [D-1:0] target_in,
  input  logic [D-1:0] prog_ctr,
  output logic         branch_en,
  output logic         reljump_en,
  output logic         absjump_en,
  output logic [D-1:0] target,
  output logic         done,
  output logic         running,
  output logic [15:0]  instr_count,
  output logic         ras_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   retire;
  logic   push;
  logic   pop;
  logic   k_cond;
  logic   k_abs;
  logic   k_call;
  logic   k_ret;

  assign k_cond = (br_kind == 3'b001);
  assign k_abs  = (br_kind == 3'b010);
  assign k_call = (br_kind == 3'b011);
  assign k_ret  = (br_kind == 3'b100);

`ifdef PC_SEQ_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [D-1:0] ras_mem [RAS_DEPTH];
  logic [AW:0]  sp;
  logic [AW:0]  sp_m1;
  logic         ras_full;
  logic         ras_empty;
  logic [D-1:0] ret_addr;
  logic         err_q;

  assign sp_m1     = sp - ONE;
  assign ras_full  = (sp == FULL);
  assign ras_empty = (sp == '0);
  // Popping an empty stack sends the program to address 0
  assign ret_addr  = ras_empty ? '0 : ras_mem[sp_m1[AW-1:0]];
  assign ras_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) begin
        if (ras_full) err_q <= 1'b1;
        else          sp    <= sp + ONE;
      end
      if (pop) begin
        if (ras_empty) err_q <= 1'b1;
        else           sp    <= sp_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !ras_full)
      ras_mem[sp[AW-1:0]] <= prog_ctr + D'(1);
  end
`else
  logic unused_ras;
  assign unused_ras = ^{prog_ctr, push, pop};
  assign ras_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + 16'd1;
  end

  always_comb begin
    state_nxt  = state;
    branch_en  = 1'b0;
    reljump_en = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    retire     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state)
      S_IDLE: begin
        branch_en  = 1'b1;
        reljump_en = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (halt_req) begin
          branch_en  = 1'b1;
          reljump_en = 1'b1;
          state_nxt  = S_HALT;
        end else if (stall) begin
          branch_en  = 1'b1;
          reljump_en = 1'b1;
        end else begin
          retire = 1'b1;
          unique case (1'b1)
            k_cond && cond_flag: begin
              branch_en  = 1'b1;
              reljump_en = 1'b1;
              target     = target_in;
            end
            k_abs: begin
              branch_en  = 1'b1;
              absjump_en = 1'b1;
              target     = target_in;
            end
            k_call: begin
              branch_en  = 1'b1;
              absjump_en = 1'b1;
              target     = target_in;
              push       = 1'b1;
            end
`ifdef PC_SEQ_RAS_EN
            k_ret: begin
              branch_en  = 1'b1;
              absjump_en = 1'b1;
              target     = ret_addr;
              pop        = 1'b1;
            end
`endif
            default: begin
              branch_en = 1'b0;
            end
          endcase
        end
      end
      S_HALT: begin
        branch_en  = 1'b1;
        reljump_en = 1'b1;
      end
      default: begin
        branch_en  = 1'b1;
        reljump_en = 1'b1;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  assign done    = (state == S_HALT);
  assign running = (state == S_RUN);

  // k_ret only decodes when the stack is built
  logic unused_kret;
  assign unused_kret = k_ret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC in the loop.
// Expectations cover both PC_SEQ_RAS_EN builds.
module tb_pc_sequencer;

  localparam int D = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         halt_req;
  logic         stall;
  logic [2:0]   br_kind;
  logic         cond_flag;
  logic [D-1:0] target_in;
  logic [D-1:0] pc;
  logic         branch_en;
  logic         reljump_en;
  logic         absjump_en;
  logic [D-1:0] target;
  logic         done;
  logic         running;
  logic [15:0]  instr_count;
  logic         ras_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D), .RAS_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .br_kind    (br_kind),
    .cond_flag  (cond_flag),
    .target_in  (target_in),
    .prog_ctr   (pc),
    .branch_en  (branch_en),
    .reljump_en (reljump_en),
    .absjump_en (absjump_en),
    .target     (target),
    .done       (done),
    .running    (running),
    .instr_count(instr_count),
    .ras_err    (ras_err)
  );

  always_ff @(posedge clk) begin
    if (reset)           pc <= '0;
    else if (!branch_en) pc <= pc + 12'd1;
    else if (absjump_en) pc <= target;
    else if (reljump_en) pc <= pc + target;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] k, input logic [D-1:0] t,
                    input logic c);
    br_kind   = k;
    target_in = t;
    cond_flag = c;
    tick();
  endtask

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    br_kind = 3'b000; cond_flag = 1'b0; target_in = '0;
    tick();
    tick();
    chk("rst_br", 32'(branch_en), 32'd1);
    chk("rst_rel", 32'(reljump_en), 32'd1);
    chk("rst_abs", 32'(absjump_en), 32'd0);
    chk("rst_tgt", 32'(target), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    chk("rst_err", 32'(ras_err), 32'd0);
    reset = 1'b0;

    tick();
    tick();
    chk("idle_pc", 32'(pc), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_pc", 32'(pc), 32'd0);
    chk("start_run", 32'(running), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      op(3'b000, '0, 1'b0);
      chk("nop_pc", 32'(pc), 32'(i));
    end
    chk("nop_cnt", 32'(instr_count), 32'd4);

    op(3'b010, 12'h010, 1'b0);
    chk("abs_pc", 32'(pc), 32'h010);
    op(3'b001, 12'hFFC, 1'b1);
    chk("rel_taken", 32'(pc), 32'h00C);
    op(3'b010, 12'h010, 1'b0);
    op(3'b001, 12'hFFC, 1'b0);
    chk("rel_not", 32'(pc), 32'h011);
    chk("cnt8", 32'(instr_count), 32'd8);

    op(3'b010, 12'h020, 1'b0);
    op(3'b011, 12'h100, 1'b0);
    chk("call_pc", 32'(pc), 32'h100);
    op(3'b000, '0, 1'b0);
    chk("call_nop", 32'(pc), 32'h101);
    op(3'b100, '0, 1'b0);
    chk("ret_pc", 32'(pc), RAS ? 32'h021 : 32'h102);
    chk("ret_err", 32'(ras_err), 32'd0);

    op(3'b010, 12'h040, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(3'b011, 12'h200, 1'b0);
      chk("stall_pc", 32'(pc), 32'h040);
      chk("stall_cnt", 32'(instr_count), 32'd13);
    end
    stall = 1'b0;
    op(3'b011, 12'h200, 1'b0);
    chk("unstall_pc", 32'(pc), 32'h200);
    op(3'b100, '0, 1'b0);
    chk("stall_ret", 32'(pc), RAS ? 32'h041 : 32'h201);
    chk("stall_err", 32'(ras_err), 32'd0);

    op(3'b010, 12'h050, 1'b0);
    op(3'b011, 12'h060, 1'b0);
    op(3'b011, 12'h070, 1'b0);
    op(3'b011, 12'h080, 1'b0);
    op(3'b011, 12'h090, 1'b0);
    chk("full_err", 32'(ras_err), 32'd0);
    op(3'b011, 12'h0A0, 1'b0);
    chk("ovf_pc", 32'(pc), 32'h0A0);
    chk("ovf_err", 32'(ras_err), RAS ? 32'd1 : 32'd0);
    op(3'b100, '0, 1'b0);
    chk("r1", 32'(pc), RAS ? 32'h081 : 32'h0A1);
    op(3'b100, '0, 1'b0);
    chk("r2", 32'(pc), RAS ? 32'h071 : 32'h0A2);
    op(3'b100, '0, 1'b0);
    chk("r3", 32'(pc), RAS ? 32'h061 : 32'h0A3);
    op(3'b100, '0, 1'b0);
    chk("r4", 32'(pc), RAS ? 32'h051 : 32'h0A4);
    op(3'b100, '0, 1'b0);
    chk("r5", 32'(pc), RAS ? 32'h000 : 32'h0A5);
    chk("cnt26", 32'(instr_count), 32'd26);

    op(3'b010, 12'h030, 1'b0);
    halt_req = 1'b1;
    stall    = 1'b1;
    op(3'b010, 12'h0FF, 1'b0);
    chk("halt_pc", 32'(pc), 32'h030);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_run", 32'(running), 32'd0);
    chk("halt_cnt", 32'(instr_count), 32'd27);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      halt_req = i[0];
      stall    = i[1];
      op(3'(i % 5), 12'h0FF, 1'b1);
      chk("frz_pc", 32'(pc), 32'h030);
      chk("frz_done", 32'(done), 32'd1);
    end
    chk("frz_cnt", 32'(instr_count), 32'd27);

    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    br_kind = 3'b000;
    #1;
    chk("rst2_pc", 32'(pc), 32'd0);
    chk("rst2_cnt", 32'(instr_count), 32'd0);
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_err", 32'(ras_err), 32'd0);
    chk("rst2_br", 32'(branch_en), 32'd1);
    tick();
    chk("rst2_idle", 32'(pc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer for the program counter. Each cycle it turns the decoded control-flow request, stall/halt inputs and condition flag into the PC's `branch_en`, `reljump_en`, `absjump_en` and `target` inputs. It also runs a run/halt state machine, a retired-instruction counter and an optional return-address stack. It sits between the decoder/ALU flags and the PC, and it is the only driver of the PC's jump inputs.

## Interface
- `D`, 12: PC / target width.
- `RAS_DEPTH`, 4: return-address stack entries (power of two, ≥2).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: leave IDLE and begin execution.
- `halt_req` in 1: current instruction is HALT.
- `stall` in 1: hold the PC this cycle.
- `br_kind` in 3: 000 none, 001 conditional relative, 010 unconditional absolute, 011 call (absolute), 100 return; 101–111 treated as 000.
- `cond_flag` in 1: branch condition from the ALU.
- `target_in` in D: two's-complement offset for kind 001, absolute address for kinds 010 and 011.
- `prog_ctr` in D: current PC value, fed back from the PC.
- `branch_en` out 1: to PC.
- `reljump_en` out 1: to PC.
- `absjump_en` out 1: to PC.
- `target` out D: to PC.
- `done` out 1: high while in HALT.
- `running` out 1: high while in RUN.
- `instr_count` out 16: retired instructions.
- `ras_err` out 1: sticky RAS overflow/underflow flag.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALT.
- "Hold" means `branch_en`=1, `reljump_en`=1, `absjump_en`=0, `target`=0. The PC adds 0, so it does not move.
- IDLE:
  - Outputs hold.
  - `start`=1 moves to RUN at the next edge.
  - PC is held at 0 during the `start` cycle.
- RUN, priority highest first:
  1. `halt_req`: hold, go to HALT, no retire.
  2. `stall`: hold, no retire, no RAS change.
  3. Kind 001 with `cond_flag`=1: `branch_en`=1, `reljump_en`=1, `target`=`target_in`.
  4. Kind 001 with `cond_flag`=0: `branch_en`=0 (increment).
  5. Kind 010: `branch_en`=1, `absjump_en`=1, `reljump_en`=0, `target`=`target_in`.
  6. Kind 011 (call): same as 010, and push `prog_ctr`+1 (mod 2^D).
  7. Kind 100 (return): absolute jump to the popped top entry.
  8. Otherwise: `branch_en`=0 and `target`=0 (plain increment).
- HALT:
  - Hold, `done`=1.
  - Ignores `start`, `halt_req` and `stall`.
  - Leaves only on `reset`.
- Outputs not listed for a case are 0.
- Relative-jump arithmetic is done by the PC, modulo 2^D. A negative offset wraps, e.g. PC 0x002 + 0xFFE = 0x000.
- `instr_count` increments by 1 in every RUN cycle that is neither halt nor stall. It wraps 0xFFFF→0x0000.
- Return-address stack:
  - Push when full: push discarded, stack unchanged, `ras_err` set.
  - Pop when empty: jump to address 0, `ras_err` set.
  - `ras_err` stays set until `reset`.

## Timing
- `branch_en`, `reljump_en`, `absjump_en`, `target`, `done` and `running` are combinational from state and current inputs. The PC acts on them at the same rising edge, so there are zero cycles of added latency.
- State, `instr_count`, stack contents, stack pointer and `ras_err` update on `posedge clk`.
- A push or pop becomes visible to the next cycle's instruction. Back-to-back call then return yields the just-pushed address.
- Reset values:
  - State IDLE, so `branch_en`=1, `reljump_en`=1, `absjump_en`=0, `target`=0.
  - `done`=0, `running`=0, `instr_count`=0.
  - Stack empty, `ras_err`=0.
- `reset` mid-RUN or in HALT takes effect at that edge and overrides every other input. Stack contents are discarded.
- `stall` together with a call or return: no push, no pop.
- `halt_req` together with `stall`: halt wins.

## Configuration
- `PC_SEQ_RAS_EN` defined:
  - Return-address stack built as described.
  - Kinds 011 and 100 behave as above.
- `PC_SEQ_RAS_EN` undefined:
  - No stack storage.
  - Kind 011 is a plain absolute jump with no push.
  - Kind 100 is treated as 000 (increment).
  - `ras_err` tied to 0.

## Test plan
- Reset, then `start` pulsed at cycle 3, run no-ops for 4 cycles → PC holds 0 through cycle 3, then reads 1, 2, 3, 4; `instr_count`=4.
- At PC 0x010, kind 001 with `target_in`=0xFFC and `cond_flag`=1 → PC 0x00C. Same with `cond_flag`=0 → PC 0x011.
- Call at PC 0x020 to 0x100, no-op, then return → PC sequence 0x100, 0x101, 0x021; `ras_err`=0. With `PC_SEQ_RAS_EN` undefined the return yields 0x102.
- Five nested calls with `RAS_DEPTH`=4 → `ras_err`=1 after the fifth. Then five returns: the fourth returns to the first call's return address, the fifth jumps to 0x000.
- `stall` held 3 cycles during a call → PC unchanged and `instr_count` unchanged for those 3 cycles; single push when the stall drops.
- `halt_req` at PC 0x030 → `done`=1 and PC frozen at 0x030 for 10 cycles despite `start`. `reset` then returns to IDLE with PC 0 and `instr_count` 0.
